nukv_fifo_arbiter: RTL
======================

# nukv_fifo_arbiter

Packet-granular round-robin arbiter that shares one `nukv_fifogen` write port among `NUM_PORTS` AXI-Stream producers. It sits directly in front of the FIFO's slave side. It grants one requester at a time and holds the grant until that requester's `tlast` beat has been written. New packets are admitted only while the FIFO is not almost-full, so each packet finishes writing in the FIFO's remaining headroom.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesters; legal range 2–16.
- `DATA_SIZE`, 64: width of one data beat.
- `SRC_BITS`, 2: width of the source index; must equal `ceil(log2(NUM_PORTS))`.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_axis_tdata`  in  `NUM_PORTS*DATA_SIZE`  requester data; port i occupies bits `[i*DATA_SIZE +: DATA_SIZE]`.
- `s_axis_tvalid`  in  `NUM_PORTS`  per-requester valid.
- `s_axis_tlast`  in  `NUM_PORTS`  per-requester end-of-packet.
- `s_axis_tready`  out  `NUM_PORTS`  per-requester ready.
- `m_axis_tdata`  out  `DATA_SIZE`  to FIFO `s_axis_tdata`.
- `m_axis_tvalid`  out  1  to FIFO `s_axis_tvalid`; this is the FIFO write enable.
- `m_axis_tlast`  out  1  end-of-packet marker, stored alongside the data when the FIFO is widened.
- `m_axis_tsource`  out  `SRC_BITS`  index of the granted port.
- `m_axis_tready`  in  1  from FIFO `s_axis_tready` (not full).
- `m_axis_talmostfull`  in  1  from FIFO `s_axis_talmostfull`.
- `pkt_count`  out  32  number of packets completed since reset; wraps on overflow.

## Operation
- State machine: IDLE and BUSY. Registers: `state`, `grant` (SRC_BITS), `last_grant` (SRC_BITS), `pkt_count`.
- IDLE:
  - Arbitration fires if any `s_axis_tvalid[i]`=1 and `m_axis_talmostfull`=0.
  - The winner is the first asserted valid found by scanning from `last_grant+1`, modulo `NUM_PORTS`, upward.
  - On arbitration: `grant` <= winner, state -> BUSY.
  - If `m_axis_talmostfull`=1, remain in IDLE regardless of requests.
- BUSY:
  - A transfer occurs when `s_axis_tvalid[grant]`=1 and `m_axis_tready`=1.
  - On a transfer with `s_axis_tlast[grant]`=1: state -> IDLE, `last_grant` <= `grant`, `pkt_count` <= `pkt_count`+1.
  - `m_axis_talmostfull` is ignored mid-packet; only `m_axis_tready` throttles.
- Datapath is combinational from the granted port:
  - `m_axis_tdata` = `s_axis_tdata[grant]`.
  - `m_axis_tlast` = `s_axis_tlast[grant]` & BUSY.
  - `m_axis_tsource` = `grant`.
- Handshake outputs:
  - `m_axis_tvalid` = BUSY & `s_axis_tvalid[grant]` & `m_axis_tready`. It is never asserted while the FIFO is full, because the FIFO writes unconditionally on valid.
  - `s_axis_tready[i]` = BUSY & (`grant`==i) & `m_axis_tready`. All other ready bits are 0.
- A requester that drops `tvalid` mid-packet keeps the grant; no other port is served until its `tlast` beat.
- Requesters must hold data stable while `tvalid`=1 and `tready`=0.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE, `grant`=0, `last_grant`=`NUM_PORTS-1`, so port 0 has first priority.
  - `pkt_count`=0.
  - All `s_axis_tready`=0; `m_axis_tvalid`=0; `m_axis_tlast`=0.
  - `m_axis_tsource`=0; `m_axis_tdata` = port 0 data.
- Reset deassertion is synchronous to `clk` in the integrating design.
- Reset mid-packet aborts the packet immediately; the FIFO is reset from the same source.
- Arbitration latency: request seen in IDLE at cycle N, grant registered at N+1, first beat transferred at N+1 at the earliest.
- Packet gap: one IDLE bubble cycle follows every `tlast` transfer, so peak throughput is L beats per L+1 cycles.
- Single-beat packet (`tvalid`=`tlast`=1): IDLE, BUSY, IDLE; `pkt_count` increments at the BUSY clock edge.
- Only the granted port affects the output datapath; requests on other ports while BUSY have no effect.
- `pkt_count` wraps from 0xFFFFFFFF to 0.

## Test plan
- Reset, then port 2 only sends a 3-beat packet A0..A2 -> grant=2 one cycle after valid; FIFO receives A0,A1,A2 in consecutive cycles; `tsource`=2; `pkt_count`=1; return to IDLE.
- Ports 0–3 all continuously valid with 2-beat packets -> grant order 0,1,2,3,0,…; each packet followed by one idle cycle; after 8 packets `pkt_count`=8.
- `m_axis_tready` low for 4 cycles mid-packet -> `m_axis_tvalid` and `s_axis_tready[grant]` low for exactly those cycles; no beat lost or duplicated.
- `m_axis_talmostfull`=1 with ports 1 and 3 valid -> state stays IDLE, no ready asserted. Deassert almost-full -> port 1 granted next cycle.
- Almost-full rises during beat 2 of a 5-beat packet -> all 5 beats are still written; next arbitration is blocked until almost-full drops.
- Assert `rst_n`=0 mid-packet on port 1 -> all outputs are at their reset values asynchronously. After release, port 0 wins over a simultaneous port 1 request.

Source files
------------

// File: rtl/nukv_fifo_arbiter.sv
// nukv_fifo_arbiter: packet-granular round-robin arbiter that shares one
// nukv_fifogen write port among NUM_PORTS AXI-Stream producers.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   s_axis_tdata/tvalid/tlast/tready  per-requester stream (port i at
//                        tdata[i*DATA_SIZE +: DATA_SIZE])
//   m_axis_tdata/tvalid/tlast/tsource to FIFO slave side
//   m_axis_tready        FIFO not full
//   m_axis_talmostfull   FIFO almost full, gates new packets only
//   pkt_count            packets completed since reset, wraps

module nukv_fifo_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_SIZE = 64,
  parameter int SRC_BITS  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS*DATA_SIZE-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]           s_axis_tlast,
  output logic [NUM_PORTS-1:0]           s_axis_tready,
  output logic [DATA_SIZE-1:0]           m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  output logic [SRC_BITS-1:0]            m_axis_tsource,
  input  logic                           m_axis_tready,
  input  logic                           m_axis_talmostfull,
  output logic [31:0]                    pkt_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]          state;
  logic [SRC_BITS-1:0] grant;
  logic [SRC_BITS-1:0] last_grant;
  logic [SRC_BITS-1:0] winner;
  logic [SRC_BITS-1:0] idx;
  logic                found;
  logic                busy;
  logic                arb;
  logic                gvalid;
  logic                glast;
  logic                xfer;

  assign busy   = (state == BUSY);
  assign gvalid = s_axis_tvalid[grant];
  assign glast  = s_axis_tlast[grant];
  assign xfer   = busy & gvalid & m_axis_tready;

  // Almost-full only blocks the start of a packet; the FIFO's
  // headroom absorbs the rest of a packet already in flight.
  assign arb = found & ~m_axis_talmostfull;

  // Scan upward from the port after the last winner, wrapping.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = SRC_BITS'((int'(last_grant) + k) % NUM_PORTS);
      if (!found && s_axis_tvalid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SRC_BITS'(NUM_PORTS - 1);
      pkt_count  <= '0;
    end else begin
      unique case (1'b1)
        !busy: begin
          if (arb) begin
            grant <= winner;
            state <= BUSY;
          end
        end
        busy: begin
          if (xfer && glast) begin
            state      <= IDLE;
            last_grant <= grant;
            pkt_count  <= pkt_count + 32'd1;
          end
        end
      endcase
    end
  end

  assign m_axis_tdata =
    s_axis_tdata[int'(grant)*DATA_SIZE +: DATA_SIZE];
  assign m_axis_tlast   = glast & busy;
  assign m_axis_tsource = grant;

  // The FIFO writes on valid alone, so valid must already
  // include its not-full signal.
  assign m_axis_tvalid = xfer;

  always_comb begin
    s_axis_tready = '0;
    if (busy && m_axis_tready) begin
      s_axis_tready[grant] = 1'b1;
    end
  end

endmodule
